// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling shuffle engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: shuffle_state_t state enum, default key length, S-box depth,
// k-counter width helper and key_byte() big-endian key byte selector.
package rc4_pkg;

    localparam int KEY_LEN_DEFAULT = 3;
    localparam int KEY_LEN_MAX     = 16;
    localparam int S_DEPTH         = 256;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_SI,
        S_LATCH_SI,
        S_RD_SJ,
        S_LATCH_SJ,
        S_WR_I,
        S_WR_J,
        S_NEXT,
        S_DONE
    } shuffle_state_t;

    // Width of the key-index counter; a 1-byte key still needs a 1-bit counter.
    function automatic int k_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Key byte k of a right-justified key of klen bytes; byte 0 is the MSB end.
    function automatic logic [7:0] key_byte(input logic [8*KEY_LEN_MAX-1:0] key,
                                            input int klen, input int k);
        logic [7:0] b;
        b = 8'h00;
        if (k >= 0 && k < klen) begin
            b = key[8*(klen-1-k) +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/ksa_key_byte_mux.sv
// Selects key byte k out of the packed secret key.
// Latency: combinational.
// Backpressure: none.
//
// Ports: secret_key (8*KEY_LEN, big-endian), k (key index), kbyte (selected byte).
module ksa_key_byte_mux
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = KEY_LEN_DEFAULT
) (
    input  logic [8*KEY_LEN-1:0]         secret_key,
    input  logic [k_width(KEY_LEN)-1:0]  k,
    output logic [7:0]                   kbyte
);

    logic [8*KEY_LEN_MAX-1:0] key_ext;

    always_comb begin
        key_ext                  = '0;
        key_ext[8*KEY_LEN-1:0]   = secret_key;
        kbyte                    = key_byte(key_ext, KEY_LEN, int'(k));
    end

endmodule

// File: rtl/ksa_shuffle_fsm.sv
// RC4 KSA second loop: j=j+s[i]+key[i mod KEY_LEN], swap s[i]/s[j], i=0..255.
// Latency: 7 cycles per iteration; done one edge after the last NEXT (1793 edges incl. start sample).
// Backpressure: level start handshake; start low in any busy state aborts to IDLE.
//
// Ports: CLOCK_50, reset (async, active-high), start, secret_key, s_q (RAM read data)
//        -> s_addr, s_data, s_wren (RAM port), done (held until start drops).
// Optional macro SHUFFLE_SELF_SWAP_SKIP_EN: an iteration whose new j equals i goes
// straight to NEXT (3 cycles, no writes); final S-box contents are unchanged.
module ksa_shuffle_fsm
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = KEY_LEN_DEFAULT,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8*KEY_LEN-1:0]  secret_key,
    input  logic [DATA_W-1:0]     s_q,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_data,
    output logic                  s_wren,
    output logic                  done
);

    localparam int KW = k_width(KEY_LEN);
    localparam logic [ADDR_W-1:0] LAST_I = '1;

    shuffle_state_t    state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d, j_q, j_d;
    logic [KW-1:0]     k_q, k_d;
    logic [DATA_W-1:0] si_q, si_d, sj_q, sj_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic              s_wren_q, s_wren_d;
    logic              done_q, done_d;

    logic [7:0]        key_b;
    logic [ADDR_W-1:0] j_sum;

    ksa_key_byte_mux #(.KEY_LEN(KEY_LEN)) u_key_mux (
        .secret_key (secret_key),
        .k          (k_q),
        .kbyte      (key_b)
    );

    assign j_sum = j_q + ADDR_W'(s_q) + ADDR_W'(key_b);

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        si_d     = si_q;
        sj_d     = sj_q;
        s_addr_d = '0;
        s_data_d = '0;
        s_wren_d = 1'b0;
        done_d   = 1'b0;

        // Losing start while busy abandons the loop; the sequencer rebuilds s anyway.
        if (state_q != S_IDLE && !start) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RD_SI;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                    end
                end
                S_RD_SI:    state_d = S_LATCH_SI;
                S_LATCH_SI: begin
                    si_d    = s_q;
                    j_d     = j_sum;
                    state_d = S_RD_SJ;
`ifdef SHUFFLE_SELF_SWAP_SKIP_EN
                    if (j_sum == i_q) begin
                        state_d = S_NEXT;
                    end
`endif
                end
                S_RD_SJ:    state_d = S_LATCH_SJ;
                S_LATCH_SJ: begin
                    sj_d    = s_q;
                    state_d = S_WR_I;
                end
                S_WR_I:     state_d = S_WR_J;
                S_WR_J:     state_d = S_NEXT;
                S_NEXT: begin
                    if (i_q == LAST_I) begin
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + 1'b1;
                        k_d     = (k_q == KW'(KEY_LEN-1)) ? '0 : k_q + 1'b1;
                        state_d = S_RD_SI;
                    end
                end
                S_DONE:     state_d = S_DONE;
                default:    state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they are valid during that
        // state's cycle; the RAM then sees the address one edge ahead of the latch.
        case (state_d)
            S_RD_SI, S_LATCH_SI, S_NEXT: s_addr_d = i_d;
            S_RD_SJ, S_LATCH_SJ:         s_addr_d = j_d;
            S_WR_I: begin
                s_addr_d = i_d;
                s_data_d = sj_d;
                s_wren_d = 1'b1;
            end
            S_WR_J: begin
                s_addr_d = j_d;
                s_data_d = si_d;
                s_wren_d = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: s_addr_d = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            si_q     <= '0;
            sj_q     <= '0;
            s_addr_q <= '0;
            s_data_q <= '0;
            s_wren_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            si_q     <= si_d;
            sj_q     <= sj_d;
            s_addr_q <= s_addr_d;
            s_data_q <= s_data_d;
            s_wren_q <= s_wren_d;
            done_q   <= done_d;
        end
    end

    assign s_addr = s_addr_q;
    assign s_data = s_data_q;
    assign s_wren = s_wren_q;
    assign done   = done_q;

endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// Bench for ksa_shuffle_fsm: two instances (3-byte and 4-byte key) each on a
// synchronous RAM model; results compared with a plain software KSA.
module tb_ksa_shuffle_fsm;
    import rc4_pkg::*;

`ifdef SHUFFLE_SELF_SWAP_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start3 = 1'b0, start4 = 1'b0;
    logic [23:0] key3 = '0;
    logic [31:0] key4 = 32'h01020304;
    logic [7:0] s_q3, s_addr3, s_data3, s_q4, s_addr4, s_data4;
    logic s_wren3, done3, s_wren4, done4;

    logic [7:0] mem3 [256];
    logic [7:0] mem4 [256];
    logic [7:0] bench_s [256];
    logic load3 = 1'b0, load4 = 1'b0;
    int wr3 = 0, wr4 = 0;

    int checks = 0;
    int failures = 0;

    int ref_s [256];
    int iter_start [256];
    int model_done;
    int model_writes;

    always #5 clk = ~clk;

    ksa_shuffle_fsm dut3 (
        .CLOCK_50(clk), .reset(reset), .start(start3), .secret_key(key3), .s_q(s_q3),
        .s_addr(s_addr3), .s_data(s_data3), .s_wren(s_wren3), .done(done3)
    );

    ksa_shuffle_fsm #(.KEY_LEN(4)) dut4 (
        .CLOCK_50(clk), .reset(reset), .start(start4), .secret_key(key4), .s_q(s_q4),
        .s_addr(s_addr4), .s_data(s_data4), .s_wren(s_wren4), .done(done4)
    );

    // Synchronous RAMs: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (load3) begin
            for (int a = 0; a < 256; a++) mem3[a] <= bench_s[a];
        end else if (s_wren3) begin
            mem3[s_addr3] <= s_data3;
        end
        s_q3 <= mem3[s_addr3];
        if (s_wren3) wr3 <= wr3 + 1;
    end

    always @(posedge clk) begin
        if (load4) begin
            for (int a = 0; a < 256; a++) mem4[a] <= bench_s[a];
        end else if (s_wren4) begin
            mem4[s_addr4] <= s_data4;
        end
        s_q4 <= mem4[s_addr4];
        if (s_wren4) wr4 <= wr4 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int w);
        return (w == 4) ? done4 : done3;
    endfunction

    function automatic logic [31:0] state_of(input int w);
        return (w == 4) ? 32'(dut4.state_q) : 32'(dut3.state_q);
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 4) start4 = v;
        else        start3 = v;
    endtask

    // Fill the bench copy and the reference copy with the same initial S-box.
    task automatic init_s(input bit rnd);
        int v;
        for (int a = 0; a < 256; a++) begin
            v = rnd ? int'($urandom_range(0, 255)) : a;
            bench_s[a] = 8'(v);
            ref_s[a]   = v;
        end
    endtask

    task automatic load_ram(input int w);
        @(negedge clk);
        if (w == 4) load4 = 1'b1;
        else        load3 = 1'b1;
        @(negedge clk);
        load3 = 1'b0;
        load4 = 1'b0;
    endtask

    // Software KSA loop 2. Edge 1 is the edge that samples start; each iteration
    // costs 7 edges, or 3 when the optional self-swap skip applies.
    task automatic model_run(input logic [31:0] key, input int klen);
        int j, t, kb, tmp;
        j = 0;
        t = 1;
        model_writes = 0;
        for (int i = 0; i < 256; i++) begin
            iter_start[i] = t;
            kb = int'((key >> (8 * (klen - 1 - (i % klen)))) & 32'hff);
            j = (j + ref_s[i] + kb) % 256;
            if (SKIP && j == i) begin
                t += 3;
            end else begin
                tmp = ref_s[i];
                ref_s[i] = ref_s[j];
                ref_s[j] = tmp;
                t += 7;
                model_writes += 2;
            end
        end
        model_done = t;
    endtask

    task automatic compare_mem(input int w, input string tag);
        int bad;
        logic [7:0] m;
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            m = (w == 4) ? mem4[a] : mem3[a];
            if (m !== 8'(ref_s[a])) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic run_full(input int w, input string tag, input int snap_edge);
        int n, wbase;
        n = 0;
        wbase = (w == 4) ? wr4 : wr3;
        @(negedge clk);
        set_start(w, 1'b1);
        while (n < 4000) begin
            @(posedge clk);
            n++;
            #1;
            if (snap_edge > 0 && n == snap_edge) begin
                chk({tag, "_after_iter2_s2"}, mem3[2], 3);
                chk({tag, "_after_iter2_s3"}, mem3[3], 2);
            end
            if (done_of(w)) break;
        end
        chk({tag, "_done_edge"}, n, model_done);
        compare_mem(w, {tag, "_final_s"});
        chk({tag, "_writes"}, ((w == 4) ? wr4 : wr3) - wbase, model_writes);
    endtask

    task automatic hold_and_stop(input int w, input string tag);
        repeat (5) @(negedge clk);
        chk({tag, "_done_held"}, done_of(w), 1);
        set_start(w, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, done_of(w), 0);
        chk({tag, "_state_idle"}, state_of(w), 32'(S_IDLE));
    endtask

    task automatic wait_edges(input int target);
        for (int n = 0; n < target; n++) @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        #1 reset = 1'b1;
        #3;
        chk("rst_s_addr", s_addr3, 0);
        chk("rst_s_data", s_data3, 0);
        chk("rst_s_wren", s_wren3, 0);
        chk("rst_done", done3, 0);
        chk("rst_state", state_of(3), 32'(S_IDLE));
        @(negedge clk);
        reset = 1'b0;

        // Identity S-box, zero key: iteration 2 swaps s[2]/s[3].
        init_s(1'b0); load_ram(3); key3 = 24'h000000;
        model_run(32'h0, 3);
        run_full(3, "t1", iter_start[3]);
        hold_and_stop(3, "t1");

        init_s(1'b0); load_ram(3); key3 = 24'h000249;
        model_run(32'h000249, 3);
        run_full(3, "t2", 0);
        hold_and_stop(3, "t2");

        // Abort while writing s[i] on i=10.
        init_s(1'b0); load_ram(3); key3 = 24'h000000;
        model_run(32'h0, 3);
        @(negedge clk); start3 = 1'b1;
        wait_edges(iter_start[10] + 4);
        chk("t3_in_wr_i_wren", s_wren3, 1);
        chk("t3_in_wr_i_addr", s_addr3, 10);
        @(negedge clk); start3 = 1'b0;
        @(posedge clk); #1;
        chk("t3_abort_wren", s_wren3, 0);
        chk("t3_abort_state", state_of(3), 32'(S_IDLE));
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done3 || s_wren3) seen++;
        end
        chk("t3_quiet_after_abort", seen, 0);
        init_s(1'b0); load_ram(3);
        model_run(32'h0, 3);
        run_full(3, "t3_rerun", 0);
        hold_and_stop(3, "t3_rerun");

        // Asynchronous reset between edges while a write is being presented.
        init_s(1'b0); load_ram(3); key3 = 24'h000249;
        model_run(32'h000249, 3);
        @(negedge clk); start3 = 1'b1;
        wait_edges(iter_start[20] + 4);
        chk("t4_pre_wren", s_wren3, 1);
        #2 reset = 1'b1;
        #1;
        chk("t4_rst_s_addr", s_addr3, 0);
        chk("t4_rst_s_data", s_data3, 0);
        chk("t4_rst_s_wren", s_wren3, 0);
        chk("t4_rst_done", done3, 0);
        chk("t4_rst_state", state_of(3), 32'(S_IDLE));
        @(negedge clk); start3 = 1'b0;
        @(negedge clk); reset = 1'b0;
        init_s(1'b0); load_ram(3);
        model_run(32'h000249, 3);
        run_full(3, "t4_rerun", 0);
        hold_and_stop(3, "t4_rerun");

        // Four-byte key: k wraps 3 -> 0.
        init_s(1'b0); load_ram(4);
        model_run(32'h01020304, 4);
        run_full(4, "t6", 0);
        hold_and_stop(4, "t6");

        // Random S-box contents and random keys.
        for (int r = 0; r < 2; r++) begin
            init_s(1'b1); load_ram(3);
            key3 = 24'($urandom);
            model_run({8'h00, key3}, 3);
            run_full(3, "rnd", 0);
            hold_and_stop(3, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
